// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//   Byte-stream boot loader for the instruction memory. It takes a framed
//   program over a valid/ready byte channel and builds 16-bit little-endian
//   words. Word k is written to byte address 2*k, which matches the PC's +2
//   stride. The core is held off until the whole image passes its XOR
//   checksum.
//
//   Frame: LEN_LO, LEN_HI (N words), N x {DATA_LO, DATA_HI}, CSUM
//          (the XOR of every byte in the frame, including CSUM, must be 0)
//
// Ports
//   Clk          in   clock, rising edge
//   Reset        in   asynchronous active-high reset
//   Start        in   one-cycle pulse: abort any load and re-arm for a frame
//   InData       in   received byte
//   InValid      in   InData valid
//   InReady      out  loader accepts a byte (transfer on InValid && InReady)
//   MemWrEn      out  one-cycle write strobe per assembled word
//   MemWrAddr    out  even byte address of the write
//   MemWrData    out  instruction word {hi byte, lo byte}
//   CpuHold      out  holds the core in reset until a good image is loaded
//   Done         out  image loaded and checksum good
//   Error        out  bad checksum or oversize length header
//   WordsLoaded  out  words written in the current frame
// ---------------------------------------------------------------------------
module program_loader #(
    parameter int l        = 16,
    parameter int MaxWords = 256
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [7:0]   InData,
    input  logic         InValid,
    output logic         InReady,
    output logic         MemWrEn,
    output logic [l-1:0] MemWrAddr,
    output logic [l-1:0] MemWrData,
    output logic         CpuHold,
    output logic         Done,
    output logic         Error,
    output logic [l-1:0] WordsLoaded
);

    typedef enum logic [2:0] {
        LenLo,
        LenHi,
        DataLo,
        DataHi,
        CsumSt,
        DoneSt,
        ErrSt
    } LoaderState;

    localparam logic [l-1:0] MaxLen = l'(MaxWords);

    LoaderState   state;
    logic [l-1:0] lenWords;
    logic [7:0]   loByte;
    logic [7:0]   runXor;
    logic [l-1:0] wordIdx;

    logic         accept;
    logic [l-1:0] lenNext;
    logic [l-1:0] wordIdxNext;

    // The loader is ready in every state that still expects frame bytes.
    // DONE and ERR refuse input until a Start or Reset re-arms the loader.
    assign InReady     = (state != DoneSt) && (state != ErrSt);
    assign accept      = InValid && InReady;
    assign lenNext     = l'({InData, lenWords[7:0]});
    assign wordIdxNext = wordIdx + l'(1);

    // The word index doubles as the count of words written, because both
    // advance on the same accepted DATA_HI byte.
    assign WordsLoaded = wordIdx;

    // Frame parser. It moves only on an accepted byte. Start overrides a byte
    // accepted in the same cycle, so that byte is dropped. The write strobe
    // defaults low each cycle. A strobe registered before Start therefore
    // still shows for its single cycle.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= LenLo;
            lenWords  <= '0;
            loByte    <= '0;
            runXor    <= '0;
            wordIdx   <= '0;
            MemWrEn   <= 1'b0;
            MemWrAddr <= '0;
            MemWrData <= '0;
            CpuHold   <= 1'b1;
            Done      <= 1'b0;
            Error     <= 1'b0;
        end else begin
            MemWrEn <= 1'b0;
            if (Start) begin
                state   <= LenLo;
                runXor  <= '0;
                wordIdx <= '0;
                CpuHold <= 1'b1;
                Done    <= 1'b0;
                Error   <= 1'b0;
            end else if (accept) begin
                runXor <= runXor ^ InData;
                case (state)
                    LenLo: begin
                        lenWords <= l'(InData);
                        state    <= LenHi;
                    end
                    LenHi: begin
                        lenWords <= lenNext;
                        if (lenNext > MaxLen) begin
                            state <= ErrSt;
                            Error <= 1'b1;
                        end else if (lenNext == '0) begin
                            state <= CsumSt;
                        end else begin
                            state <= DataLo;
                        end
                    end
                    DataLo: begin
                        loByte <= InData;
                        state  <= DataHi;
                    end
                    DataHi: begin
                        MemWrEn   <= 1'b1;
                        MemWrAddr <= wordIdx << 1;
                        MemWrData <= l'({InData, loByte});
                        wordIdx   <= wordIdxNext;
                        state     <= (wordIdxNext == lenWords) ? CsumSt : DataLo;
                    end
                    CsumSt: begin
                        if ((runXor ^ InData) == 8'h00) begin
                            state   <= DoneSt;
                            Done    <= 1'b1;
                            CpuHold <= 1'b0;
                        end else begin
                            state <= ErrSt;
                            Error <= 1'b1;
                        end
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader
//   Directed and randomized frames for program_loader. Expected writes and the
//   final status come from the frame bytes alone. Word k is expected at
//   address 2*k with data {byte 3+2k, byte 2+2k}. The frame is expected to be
//   good when the XOR of all its bytes is zero and N is no larger than
//   MaxWords.
// ---------------------------------------------------------------------------
module tb_program_loader;

    localparam int l        = 16;
    localparam int MaxWords = 256;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Start;
    logic [7:0]   InData;
    logic         InValid;
    logic         InReady;
    logic         MemWrEn;
    logic [l-1:0] MemWrAddr;
    logic [l-1:0] MemWrData;
    logic         CpuHold;
    logic         Done;
    logic         Error;
    logic [l-1:0] WordsLoaded;

    logic [7:0]  frameQ[$];
    logic [31:0] gotQ[$];

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    program_loader #(.l(l), .MaxWords(MaxWords)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .InData     (InData),
        .InValid    (InValid),
        .InReady    (InReady),
        .MemWrEn    (MemWrEn),
        .MemWrAddr  (MemWrAddr),
        .MemWrData  (MemWrData),
        .CpuHold    (CpuHold),
        .Done       (Done),
        .Error      (Error),
        .WordsLoaded(WordsLoaded)
    );

    always #5 Clk = ~Clk;

    // Record every write strobe as {address, data}.
    always @(negedge Clk) begin
        if (MemWrEn === 1'b1) gotQ.push_back({MemWrAddr, MemWrData});
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Send frameQ, beginning at a negedge. With probability gapPct the bench
    // idles for a cycle. Sending stops once the loader stops accepting.
    task automatic applyStimulus(input int gapPct);
        int idx    = 0;
        int budget = 0;
        while (idx < frameQ.size() && budget < 20000) begin
            budget++;
            if (int'($urandom_range(99)) < gapPct) begin
                InValid = 1'b0;
                @(negedge Clk);
            end else begin
                if (InReady !== 1'b1) break;
                InValid = 1'b1;
                InData  = frameQ[idx];
                @(negedge Clk);
                idx++;
            end
        end
        InValid = 1'b0;
        if (budget >= 20000) checkOutput("sendBudget", idx, frameQ.size());
    endtask

    task automatic startPulse();
        Start   = 1'b1;
        InValid = 1'b0;
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        gotQ.delete();
    endtask

    task automatic appendCsum(input bit good);
        logic [7:0] x;
        x = 8'h00;
        foreach (frameQ[i]) x ^= frameQ[i];
        frameQ.push_back(good ? x : (x ^ (8'h01 << $urandom_range(7))));
    endtask

    task automatic buildFrame(input int n, input bit good);
        frameQ.delete();
        frameQ.push_back(n[7:0]);
        frameQ.push_back(n[15:8]);
        for (int i = 0; i < 2 * n; i++) frameQ.push_back(8'($urandom));
        appendCsum(good);
    endtask

    // Compare the observed writes and the final status with frameQ.
    task automatic compareFrame(input string tag);
        int         n;
        int         expWrites;
        bit         good;
        logic [7:0] x;
        repeat (2) @(negedge Clk);
        n         = int'({frameQ[1], frameQ[0]});
        expWrites = (n > MaxWords) ? 0 : n;
        x         = 8'h00;
        foreach (frameQ[i]) x ^= frameQ[i];
        good = (n <= MaxWords) && (x == 8'h00);
        checkOutput({tag, ".writeCount"}, gotQ.size(), expWrites);
        for (int k = 0; k < gotQ.size() && k < expWrites; k++) begin
            checkOutput($sformatf("%s.addr%0d", tag, k), gotQ[k][31:16], 2 * k);
            checkOutput($sformatf("%s.data%0d", tag, k), gotQ[k][15:0],
                        {frameQ[3 + 2 * k], frameQ[2 + 2 * k]});
        end
        checkOutput({tag, ".Done"}, Done, good);
        checkOutput({tag, ".Error"}, Error, !good);
        checkOutput({tag, ".CpuHold"}, CpuHold, !good);
        checkOutput({tag, ".InReady"}, InReady, 0);
        checkOutput({tag, ".WordsLoaded"}, WordsLoaded, expWrites);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".InReady"}, InReady, 1);
        checkOutput({tag, ".CpuHold"}, CpuHold, 1);
        checkOutput({tag, ".MemWrEn"}, MemWrEn, 0);
        checkOutput({tag, ".MemWrAddr"}, MemWrAddr, 0);
        checkOutput({tag, ".MemWrData"}, MemWrData, 0);
        checkOutput({tag, ".Done"}, Done, 0);
        checkOutput({tag, ".Error"}, Error, 0);
        checkOutput({tag, ".WordsLoaded"}, WordsLoaded, 0);
    endtask

    initial begin
        Reset   = 1'b1;
        Start   = 1'b0;
        InValid = 1'b0;
        InData  = 8'h00;
        #1;
        checkResetValues("reset");
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

        // Two-word frame, one byte per cycle, with a good checksum.
        frameQ.delete();
        frameQ.push_back(8'h02); frameQ.push_back(8'h00);
        frameQ.push_back(8'h13); frameQ.push_back(8'h00);
        frameQ.push_back(8'h37); frameQ.push_back(8'hA1);
        appendCsum(1'b1);
        applyStimulus(0);
        compareFrame("good2");

        // The same frame with a corrupted checksum.
        startPulse();
        frameQ.pop_back();
        appendCsum(1'b0);
        applyStimulus(0);
        compareFrame("badCsum");

        // An empty image.
        startPulse();
        frameQ.delete();
        frameQ.push_back(8'h00); frameQ.push_back(8'h00); frameQ.push_back(8'h00);
        applyStimulus(0);
        compareFrame("empty");

        // An oversize length header (0x0101 words).
        startPulse();
        frameQ.delete();
        frameQ.push_back(8'h01); frameQ.push_back(8'h01);
        frameQ.push_back(8'hAA); frameQ.push_back(8'hBB); frameQ.push_back(8'hCC);
        applyStimulus(0);
        compareFrame("oversize");

        // The two-word frame again, with random idle gaps.
        startPulse();
        frameQ.delete();
        frameQ.push_back(8'h02); frameQ.push_back(8'h00);
        frameQ.push_back(8'h13); frameQ.push_back(8'h00);
        frameQ.push_back(8'h37); frameQ.push_back(8'hA1);
        appendCsum(1'b1);
        applyStimulus(50);
        compareFrame("gaps");

        // Random frames.
        for (int r = 0; r < 6; r++) begin
            startPulse();
            buildFrame(int'($urandom_range(12)), $urandom_range(3) != 0);
            applyStimulus(40);
            compareFrame($sformatf("rand%0d", r));
        end

        // Abort after the first word. The byte sent alongside Start must be
        // dropped.
        startPulse();
        frameQ.delete();
        frameQ.push_back(8'h02); frameQ.push_back(8'h00);
        frameQ.push_back(8'h13); frameQ.push_back(8'h00);
        applyStimulus(0);
        @(negedge Clk);
        checkOutput("abort.preWrites", gotQ.size(), 1);
        checkOutput("abort.preWordsLoaded", WordsLoaded, 1);
        Start   = 1'b1;
        InValid = 1'b1;
        InData  = 8'h55;
        @(negedge Clk);
        Start   = 1'b0;
        InValid = 1'b0;
        checkOutput("abort.WordsLoaded", WordsLoaded, 0);
        checkOutput("abort.CpuHold", CpuHold, 1);
        checkOutput("abort.InReady", InReady, 1);
        gotQ.delete();
        buildFrame(3, 1'b1);
        applyStimulus(20);
        compareFrame("restart");

        // Assert Reset mid-frame while a write strobe is showing.
        startPulse();
        frameQ.delete();
        frameQ.push_back(8'h01); frameQ.push_back(8'h00);
        frameQ.push_back(8'hAA); frameQ.push_back(8'hBB);
        applyStimulus(0);
        checkOutput("midReset.preStrobe", MemWrEn, 1);
        #2;
        Reset = 1'b1;
        #1;
        checkResetValues("midReset");
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        checkOutput("postReset.MemWrEn", MemWrEn, 0);
        checkOutput("postReset.InReady", InReady, 1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
